// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
//
// Performs data-memory loads and stores with WAIT_CYCLES wait states, resolves
// taken branches back to fetch, and drives the MEM/WB pipeline register. While an
// access is in progress, stall freezes upstream stages and a bubble is sent into
// MEM/WB.
//
// Optional feature: define MEM_STAGE_STATS_EN to build saturating 16-bit
// load/store counters. When it is undefined, load_count and store_count are tied to 0.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mem_to_reg, reg_write, branch, mem_write, mem_read, pc_branch, zero,
//   alu_result, data2, dst
//                       registered EX/MEM outputs
//   pc_src, pc_target   branch resolution to fetch (combinational)
//   stall               freeze for PC, IF/ID, ID/EX and EX/MEM (combinational)
//   *_wb                MEM/WB pipeline register
//   load_count, store_count
//                       completed-access statistics
module mem_stage #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic        branch,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [6:0]  pc_branch,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] data2,
    input  logic [4:0]  dst,
    output logic        pc_src,
    output logic [6:0]  pc_target,
    output logic        stall,
    output logic        mem_to_reg_wb,
    output logic        reg_write_wb,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [4:0]  dst_wb,
    output logic [15:0] load_count,
    output logic [15:0] store_count
);

    localparam logic [2:0] WaitCnt = WAIT_CYCLES[2:0];
    localparam bit         NoWait  = (WAIT_CYCLES == 0);

    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        access;
    logic        completing;
    logic        done;
    logic [ADDR_W-1:0] addr;

    logic [31:0] mem [(1 << ADDR_W)];

    assign access = mem_read | mem_write;
    // Upper bits drop out, so addresses wrap modulo the memory size.
    assign addr   = alu_result[ADDR_W+1:2];

    assign pc_src    = branch & zero;
    assign pc_target = pc_branch;

    always_comb begin
        completing = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                completing = NoWait;
                if (access && !NoWait) begin
                    state_d = StWait;
                    cnt_d   = 3'd1;
                end
            end
            StWait: begin
                if (cnt_q == WaitCnt) begin
                    completing = 1'b1;
                    state_d    = StIdle;
                    cnt_d      = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign stall = access & ~completing;
    assign done  = access & completing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No reset on the array; rst only blocks the write of an aborted access.
    always_ff @(posedge clk) begin
        if (!rst && done && mem_write) begin
            mem[addr] <= data2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_to_reg_wb <= 1'b0;
            reg_write_wb  <= 1'b0;
            read_data_wb  <= 32'd0;
            alu_result_wb <= 32'd0;
            dst_wb        <= 5'd0;
        end else if (stall) begin
            mem_to_reg_wb <= 1'b0;
            reg_write_wb  <= 1'b0;
        end else begin
            mem_to_reg_wb <= mem_to_reg;
            reg_write_wb  <= reg_write;
            alu_result_wb <= alu_result;
            dst_wb        <= dst;
            // Non-blocking read returns pre-write contents on a combined read/write.
            if (mem_read) begin
                read_data_wb <= mem[addr];
            end
        end
    end

`ifdef MEM_STAGE_STATS_EN
    logic [15:0] load_cnt_q, store_cnt_q;
    logic        load_done, store_done;

    // A combined read/write counts as a store only.
    assign load_done  = done & mem_read & ~mem_write;
    assign store_done = done & mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= 16'd0;
            store_cnt_q <= 16'd0;
        end else begin
            if (load_done && load_cnt_q != 16'hFFFF) begin
                load_cnt_q <= load_cnt_q + 16'd1;
            end
            if (store_done && store_cnt_q != 16'hFFFF) begin
                store_cnt_q <= store_cnt_q + 16'd1;
            end
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
`else
    assign load_count  = 16'd0;
    assign store_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (WAIT_CYCLES=2, ADDR_W=7).
// Stimulus pushes the expected MEM/WB contents into a scoreboard queue; a monitor
// pops and compares whenever an instruction retires (issued and not stalled).
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_to_reg, reg_write, branch, mem_write, mem_read, zero;
    logic [6:0]  pc_branch;
    logic [31:0] alu_result, data2;
    logic [4:0]  dst;
    logic        pc_src, stall, mem_to_reg_wb, reg_write_wb;
    logic [6:0]  pc_target;
    logic [31:0] read_data_wb, alu_result_wb;
    logic [4:0]  dst_wb;
    logic [15:0] load_count, store_count;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
    } wb_t;

    wb_t   sb_q[$];
    string sb_name[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    logic  in_valid;
    logic  mon_ret;
    wb_t   mon_exp;
    string mon_name;
    logic [31:0] last_rd;
    logic [15:0] exp_ld, exp_st;

    mem_stage #(.ADDR_W(7), .WAIT_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .branch        (branch),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .pc_branch     (pc_branch),
        .zero          (zero),
        .alu_result    (alu_result),
        .data2         (data2),
        .dst           (dst),
        .pc_src        (pc_src),
        .pc_target     (pc_target),
        .stall         (stall),
        .mem_to_reg_wb (mem_to_reg_wb),
        .reg_write_wb  (reg_write_wb),
        .read_data_wb  (read_data_wb),
        .alu_result_wb (alu_result_wb),
        .dst_wb        (dst_wb),
        .load_count    (load_count),
        .store_count   (store_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic wb_t wb_now();
        wb_t w;
        w = '{m2r: mem_to_reg_wb, rw: reg_write_wb, rd: read_data_wb,
              alu: alu_result_wb, dst: dst_wb};
        return w;
    endfunction

    // Monitor: an edge where an issued instruction is not stalled retires it.
    always @(posedge clk) begin
        mon_ret = in_valid && !stall && !rst;
        #2;
        if (mon_ret) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 96'd1, 96'd0);
            end else begin
                mon_exp  = sb_q.pop_front();
                mon_name = sb_name.pop_front();
                check(mon_name, 96'(wb_now()), 96'(mon_exp));
            end
        end
    end

    task automatic clear_inputs();
        mem_to_reg = 0; reg_write = 0; branch = 0; mem_write = 0; mem_read = 0;
        zero = 0; pc_branch = '0; alu_result = '0; data2 = '0; dst = '0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear_inputs();
    endtask

    // Present one instruction and hold it until it stops stalling.
    task automatic issue(input string name, input logic m2r, input logic rw, input logic br,
                         input logic z, input logic mw, input logic mr,
                         input logic [6:0] pcb, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [4:0] d,
                         input logic [31:0] load_val, input logic exp_pc_src);
        wb_t e;
        int  n;
        @(negedge clk);
        mem_to_reg = m2r; reg_write = rw; branch = br; zero = z; mem_write = mw;
        mem_read = mr; pc_branch = pcb; alu_result = alu; data2 = d2; dst = d;
        in_valid = 1'b1;
        if (mr) last_rd = load_val;
        e = '{m2r: m2r, rw: rw, rd: last_rd, alu: alu, dst: d};
        sb_q.push_back(e);
        sb_name.push_back(name);
        #1;
        check({name, "_pc_src"}, 96'(pc_src), 96'(exp_pc_src));
        if (br) check({name, "_pc_target"}, 96'(pc_target), 96'(pcb));
        n = 0;
        while (stall && n < 20) begin
            n++;
            @(negedge clk);
            #1;
            check({name, "_bubble"}, 96'({reg_write_wb, mem_to_reg_wb}), 96'd0);
        end
        check({name, "_stall_cycles"}, 96'(n), 96'((mw | mr) ? 2 : 0));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        last_rd  = '0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_wb", 96'(wb_now()), 96'd0);
        check("reset_stall", 96'(stall), 96'd0);
        check("reset_counts", 96'({load_count, store_count}), 96'd0);
        rst = 1'b0;

        //     name          m2r rw br z mw mr pcb    alu        d2            dst load_val     pc_src
        issue("st_beef",     0, 0, 0, 0, 1, 0, 7'h0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0);
        issue("ld_beef",     1, 1, 0, 0, 0, 1, 7'h0, 32'h10,   32'h0,        5, 32'hDEADBEEF, 0);
        issue("alu_1234",    0, 1, 0, 0, 0, 0, 7'h0, 32'h1234, 32'h0,        7, 32'h0,        0);
        issue("br_taken",    0, 0, 1, 1, 0, 0, 7'h2A, 32'h0,   32'h0,        0, 32'h0,        1);
        issue("br_not",      0, 0, 1, 0, 0, 0, 7'h2A, 32'h0,   32'h0,        0, 32'h0,        0);
        issue("st_wrap",     0, 0, 0, 0, 1, 0, 7'h0, 32'h200,  32'h55,       0, 32'h0,        0);
        issue("ld_wrap",     1, 1, 0, 0, 0, 1, 7'h0, 32'h0,    32'h0,        9, 32'h55,       0);
        issue("st_a5",       0, 0, 0, 0, 1, 0, 7'h0, 32'h14,   32'hA5A5,     0, 32'h0,        0);
        issue("ld_a5",       1, 1, 0, 0, 0, 1, 7'h0, 32'h14,   32'h0,        3, 32'hA5A5,     0);
        issue("ld_beef2",    1, 1, 0, 0, 0, 1, 7'h0, 32'h10,   32'h0,        4, 32'hDEADBEEF, 0);
        issue("rdwr_both",   0, 0, 0, 0, 1, 1, 7'h0, 32'h14,   32'h777,      2, 32'hA5A5,     0);
        issue("ld_777",      1, 1, 0, 0, 0, 1, 7'h0, 32'h14,   32'h0,        6, 32'h777,      0);
        issue("st_w3",       0, 0, 0, 0, 1, 0, 7'h0, 32'h0C,   32'h33,       0, 32'h0,        0);
        idle();

`ifdef MEM_STAGE_STATS_EN
        exp_ld = 16'd5; exp_st = 16'd5;
`else
        exp_ld = 16'd0; exp_st = 16'd0;
`endif
        #1;
        check("load_count", 96'(load_count), 96'(exp_ld));
        check("store_count", 96'(store_count), 96'(exp_st));

        // Reset during the first wait cycle of a store to word 3.
        @(negedge clk);
        mem_write = 1; alu_result = 32'h0C; data2 = 32'h99;
        #1;
        check("abort_stall0", 96'(stall), 96'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_stall1", 96'(stall), 96'd1);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        check("abort_stall_drop", 96'(stall), 96'd0);
        check("abort_wb", 96'(wb_now()), 96'd0);
        check("abort_counts", 96'({load_count, store_count}), 96'd0);
        last_rd = '0;
        issue("ld_w3",       1, 1, 0, 0, 0, 1, 7'h0, 32'h0C,   32'h0,        1, 32'h33,       0);
        idle();
        repeat (3) @(negedge clk);

`ifdef MEM_STAGE_STATS_EN
        exp_ld = 16'd1;
`else
        exp_ld = 16'd0;
`endif
        #1;
        check("load_count_final", 96'(load_count), 96'(exp_ld));
        check("store_count_final", 96'(store_count), 96'd0);
        check("scoreboard_empty", 96'(sb_q.size()), 96'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM latch and consumes its registered control and data outputs. It performs data-memory loads and stores with a configurable number of wait states and resolves taken branches back to the fetch stage. It also drives the MEM/WB pipeline register, inserting a bubble whenever it stalls the pipeline.

## Interface
Parameters:
- ADDR_W, 7: word-address width; data memory holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: extra cycles per load/store, legal range 0..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_to_reg  in  1  WB control from EX/MEM.
- reg_write  in  1  WB control from EX/MEM.
- branch  in  1  instruction is a conditional branch.
- mem_write  in  1  store request.
- mem_read  in  1  load request.
- pc_branch  in  7  branch target.
- zero  in  1  ALU zero flag.
- alu_result  in  32  effective address for loads/stores, or the ALU value.
- data2  in  32  store data.
- dst  in  5  destination register.
- pc_src  out  1  combinational; branch & zero.
- pc_target  out  7  combinational; equals pc_branch.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- mem_to_reg_wb  out  1  MEM/WB register.
- reg_write_wb  out  1  MEM/WB register.
- read_data_wb  out  32  MEM/WB register.
- alu_result_wb  out  32  MEM/WB register.
- dst_wb  out  5  MEM/WB register.
- load_count  out  16  statistics counter; see Configuration.
- store_count  out  16  statistics counter; see Configuration.

## Operation
- access = mem_read | mem_write. Word address = alu_result[ADDR_W+1:2].
  - alu_result[1:0] is ignored.
  - Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- FSM states are IDLE and WAIT. A 3-bit counter cnt is used in WAIT.
  - IDLE, access, WAIT_CYCLES=0: the access completes this cycle; state stays IDLE.
  - IDLE, access, WAIT_CYCLES>0: go to WAIT with cnt=1.
  - WAIT, cnt<WAIT_CYCLES: cnt increments.
  - WAIT, cnt==WAIT_CYCLES: the access completes; go to IDLE and set cnt=0.
- stall = access & ~completing. A completing cycle is either IDLE with WAIT_CYCLES=0, or WAIT with cnt==WAIT_CYCLES.
- Completion edge:
  - A store writes data2 to memory exactly once.
  - A load captures mem[addr] into read_data_wb.
  - If mem_read and mem_write are both set, the write happens and read_data_wb gets the pre-write contents.
- MEM/WB register updates on every edge with no enable:
  - When stall=1: bubble. reg_write_wb=0 and mem_to_reg_wb=0; read_data_wb, alu_result_wb and dst_wb hold their values.
  - Otherwise: it takes mem_to_reg, reg_write, alu_result and dst. read_data_wb takes load data on a load and holds its value on non-loads.
- Branch resolution is independent of the FSM; branch instructions never stall.
- Reset:
  - State → IDLE, cnt=0.
  - All *_wb outputs → 0; load_count and store_count → 0.
  - Memory contents are not cleared.
  - An in-flight access is aborted and no write occurs.

## Timing
- Every load or store occupies WAIT_CYCLES+1 cycles in this stage.
- stall is high for the first WAIT_CYCLES of those cycles and low in the completing cycle.
- Load data becomes visible on read_data_wb one edge after the completing cycle.
- A non-memory instruction passes through with 1-cycle latency.
- Back-to-back accesses: the next access starts in IDLE on the cycle after completion, with no idle gap.
- A store followed by a load of the same address returns the stored value.
- Upstream must hold all inputs stable while stall=1. Input changes during WAIT are undefined.

## Configuration
- MEM_STAGE_STATS_EN defined:
  - load_count increments at each completed load; store_count increments at each completed store.
  - Both counters are 16-bit and saturate at 0xFFFF.
  - An access with both mem_read and mem_write set counts as a store only.
- MEM_STAGE_STATS_EN undefined: the counters are not built; load_count and store_count are tied to 0.

## Test plan
All scenarios use WAIT_CYCLES=2.
- Store 0xDEADBEEF at alu_result=0x10, then load 0x10 with dst=5, reg_write=1, mem_to_reg=1.
  - stall is high for 2 cycles per access.
  - After completion: read_data_wb=0xDEADBEEF, dst_wb=5, reg_write_wb=1.
- ALU instruction with alu_result=0x1234 and dst=7, no access.
  - stall=0; next edge: alu_result_wb=0x1234, reg_write_wb=1.
- branch=1, zero=1, pc_branch=0x2A → pc_src=1, pc_target=0x2A, stall=0.
- branch=1, zero=0 → pc_src=0.
- Wrap: store 0x55 at alu_result=0x200 (word 128 → 0), then load alu_result=0x0 → 0x55.
- Assert rst in the first WAIT cycle of a store to word 3.
  - Word 3 keeps its old value; stall drops the following cycle; all *_wb outputs=0.
- With MEM_STAGE_STATS_EN: 3 loads and 2 stores → load_count=3, store_count=2.
- Without MEM_STAGE_STATS_EN: load_count and store_count stay 0.
